// File: rtl/branch_issue_queue_pkg.sv
// Shared types for the branch issue queue: compare ops, datapath word and queue entry layout.
package branch_issue_queue_pkg;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } branch_funct3_t;

    // Tag width stored in each entry; the top converts its TAG_W ports to and from this width.
    localparam int BR_TAG_W = 3;

    typedef struct packed {
        branch_funct3_t        op;
        rv32i_word             pc;
        rv32i_word             imm;
        logic [BR_TAG_W-1:0]   rob_tag;
        logic                  src1_valid;
        logic [BR_TAG_W-1:0]   src1_tag;
        rv32i_word             src1_data;
        logic                  src2_valid;
        logic [BR_TAG_W-1:0]   src2_tag;
        rv32i_word             src2_data;
    } br_iq_entry_t;

    function automatic rv32i_word branch_target(input rv32i_word pc, input rv32i_word imm);
        return pc + imm;
    endfunction

endpackage

// File: rtl/branch_issue_queue_if.sv
// Dispatch, CDB snoop, flush and result signals of the branch issue queue.
interface branch_issue_queue_if #(
    parameter int TAG_W = 3
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // a producer holds valid and payload steady until that edge, and ready never depends on valid.
    logic              flush;

    logic              disp_valid;
    logic              disp_ready;
    logic [2:0]        disp_op;
    logic [31:0]       disp_pc;
    logic [31:0]       disp_imm;
    logic [TAG_W-1:0]  disp_rob_tag;
    logic              disp_src1_valid;
    logic              disp_src2_valid;
    logic [TAG_W-1:0]  disp_src1_tag;
    logic [TAG_W-1:0]  disp_src2_tag;
    logic [31:0]       disp_src1_data;
    logic [31:0]       disp_src2_data;

    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [31:0]       cdb_data;

    logic              res_valid;
    logic              res_ready;
    logic [TAG_W-1:0]  res_rob_tag;
    logic              res_taken;
    logic [31:0]       res_target;

    modport master (
        output flush,
        output disp_valid, disp_op, disp_pc, disp_imm, disp_rob_tag,
        output disp_src1_valid, disp_src2_valid, disp_src1_tag, disp_src2_tag,
        output disp_src1_data, disp_src2_data,
        output cdb_valid, cdb_tag, cdb_data,
        output res_ready,
        input  disp_ready,
        input  res_valid, res_rob_tag, res_taken, res_target
    );

    modport slave (
        input  flush,
        input  disp_valid, disp_op, disp_pc, disp_imm, disp_rob_tag,
        input  disp_src1_valid, disp_src2_valid, disp_src1_tag, disp_src2_tag,
        input  disp_src1_data, disp_src2_data,
        input  cdb_valid, cdb_tag, cdb_data,
        input  res_ready,
        output disp_ready,
        output res_valid, res_rob_tag, res_taken, res_target
    );

endinterface

// File: rtl/branch_issue_queue_alu.sv
// Shared conditional-branch comparator; reserved funct3 codes resolve as not taken.
module branch_alu
    import branch_issue_queue_pkg::*;
(
    input  branch_funct3_t op,
    input  rv32i_word      a,
    input  rv32i_word      b,
    output logic           taken
);

    always_comb begin
        taken = 1'b0;
        case (op)
            BR_EQ:   taken = (a == b);
            BR_NE:   taken = (a != b);
            BR_LT:   taken = ($signed(a) <  $signed(b));
            BR_GE:   taken = ($signed(a) >= $signed(b));
            BR_LTU:  taken = (a <  b);
            BR_GEU:  taken = (a >= b);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_issue_queue.sv
// In-order branch issue queue: holds dispatched branches until operands arrive via the CDB,
// issues the head to the comparator and registers the result in a one-entry skid stage.
module branch_issue_queue
    import branch_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_issue_queue_if.slave   bi
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    br_iq_entry_t        entries [DEPTH];
    logic                occ     [DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [PTR_W:0]      count;

    logic                res_valid_q;
    logic [TAG_W-1:0]    res_tag_q;
    logic                res_taken_q;
    rv32i_word           res_target_q;

    logic                full;
    logic                disp_fire;
    logic                issue;
    logic                alu_taken;
    logic [BR_TAG_W-1:0] cdb_tag_x;
    br_iq_entry_t        new_e;
    logic                wake1   [DEPTH];
    logic                wake2   [DEPTH];

    assign full          = (count == FULL_COUNT);
    assign bi.disp_ready = !full;
    assign cdb_tag_x     = BR_TAG_W'(bi.cdb_tag);

    // Full blocks dispatch even when the head leaves this cycle, so ready stays a pure register decode.
    assign disp_fire = bi.disp_valid && !full && !bi.flush;
    assign issue     = occ[head] && entries[head].src1_valid && entries[head].src2_valid &&
                       (!res_valid_q || bi.res_ready);

    for (genvar i = 0; i < DEPTH; i++) begin : g_wake
        assign wake1[i] = bi.cdb_valid && occ[i] && !entries[i].src1_valid &&
                          (entries[i].src1_tag == cdb_tag_x);
        assign wake2[i] = bi.cdb_valid && occ[i] && !entries[i].src2_valid &&
                          (entries[i].src2_tag == cdb_tag_x);
    end

    always_comb begin
        new_e            = '0;
        new_e.op         = branch_funct3_t'(bi.disp_op);
        new_e.pc         = bi.disp_pc;
        new_e.imm        = bi.disp_imm;
        new_e.rob_tag    = BR_TAG_W'(bi.disp_rob_tag);
        new_e.src1_tag   = BR_TAG_W'(bi.disp_src1_tag);
        new_e.src2_tag   = BR_TAG_W'(bi.disp_src2_tag);
        new_e.src1_valid = bi.disp_src1_valid;
        new_e.src1_data  = bi.disp_src1_data;
        new_e.src2_valid = bi.disp_src2_valid;
        new_e.src2_data  = bi.disp_src2_data;
        // A producer broadcasting in the dispatch cycle would otherwise be missed forever.
        if (!bi.disp_src1_valid && bi.cdb_valid && (new_e.src1_tag == cdb_tag_x)) begin
            new_e.src1_valid = 1'b1;
            new_e.src1_data  = bi.cdb_data;
        end
        if (!bi.disp_src2_valid && bi.cdb_valid && (new_e.src2_tag == cdb_tag_x)) begin
            new_e.src2_valid = 1'b1;
            new_e.src2_data  = bi.cdb_data;
        end
    end

    branch_alu u_alu (
        .op    (entries[head].op),
        .a     (entries[head].src1_data),
        .b     (entries[head].src2_data),
        .taken (alu_taken)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                occ[i]     <= 1'b0;
                entries[i] <= '0;
            end
        end else if (bi.flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                occ[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wake1[i]) begin
                    entries[i].src1_valid <= 1'b1;
                    entries[i].src1_data  <= bi.cdb_data;
                end
                if (wake2[i]) begin
                    entries[i].src2_valid <= 1'b1;
                    entries[i].src2_data  <= bi.cdb_data;
                end
            end
            if (issue) begin
                occ[head] <= 1'b0;
                head      <= head + PTR_W'(1);
            end
            // The tail slot is never occupied when dispatch fires, so it cannot collide with a wakeup.
            if (disp_fire) begin
                entries[tail] <= new_e;
                occ[tail]     <= 1'b1;
                tail          <= tail + PTR_W'(1);
            end
            case ({disp_fire, issue})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q  <= 1'b0;
            res_tag_q    <= '0;
            res_taken_q  <= 1'b0;
            res_target_q <= '0;
        end else if (bi.flush) begin
            res_valid_q <= 1'b0;
        end else if (issue) begin
            res_valid_q  <= 1'b1;
            res_tag_q    <= TAG_W'(entries[head].rob_tag);
            res_taken_q  <= alu_taken;
            res_target_q <= branch_target(entries[head].pc, entries[head].imm);
        end else if (bi.res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    assign bi.res_valid   = res_valid_q;
    assign bi.res_rob_tag = res_tag_q;
    assign bi.res_taken   = res_taken_q;
    assign bi.res_target  = res_target_q;

endmodule

// File: tb/tb_branch_issue_queue.sv
// Self-checking bench for branch_issue_queue: directed scenarios plus randomized traffic against a queue model.
module tb_branch_issue_queue;

    localparam int DEPTH = 4;
    localparam int TAG_W = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    branch_issue_queue_if #(.TAG_W(TAG_W)) bi ();

    branch_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk (clk),
        .rst (rst),
        .bi  (bi)
    );

    typedef struct {
        logic [2:0]       op;
        logic [31:0]      pc;
        logic [31:0]      imm;
        logic [TAG_W-1:0] rob;
        logic             s1v;
        logic [TAG_W-1:0] s1t;
        logic [31:0]      s1d;
        logic             s2v;
        logic [TAG_W-1:0] s2t;
        logic [31:0]      s2d;
    } mentry_t;

    mentry_t          mq[$];
    logic             m_rv;
    logic             m_taken;
    logic [TAG_W-1:0] m_tag;
    logic [31:0]      m_target;

    logic [TAG_W-1:0] exp_q[$];
    int               n_checks = 0;
    int               n_errors = 0;
    bit               chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    function automatic logic ref_taken(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        mq.delete();
        m_rv     = 1'b0;
        m_taken  = 1'b0;
        m_tag    = '0;
        m_target = '0;
    endtask

    // Next-state of the model from the inputs present at this rising edge.
    task automatic model_step();
        mentry_t e;
        logic    do_issue;
        logic    acc;
        if (bi.flush) begin
            mq.delete();
            m_rv = 1'b0;
            return;
        end
        do_issue = (mq.size() > 0) && mq[0].s1v && mq[0].s2v && (!m_rv || bi.res_ready);
        acc      = bi.disp_valid && (mq.size() < DEPTH);
        if (do_issue) begin
            e        = mq.pop_front();
            m_rv     = 1'b1;
            m_tag    = e.rob;
            m_taken  = ref_taken(e.op, e.s1d, e.s2d);
            m_target = e.pc + e.imm;
        end else if (bi.res_ready) begin
            m_rv = 1'b0;
        end
        if (bi.cdb_valid) begin
            foreach (mq[i]) begin
                if (!mq[i].s1v && mq[i].s1t == bi.cdb_tag) begin
                    mq[i].s1v = 1'b1;
                    mq[i].s1d = bi.cdb_data;
                end
                if (!mq[i].s2v && mq[i].s2t == bi.cdb_tag) begin
                    mq[i].s2v = 1'b1;
                    mq[i].s2d = bi.cdb_data;
                end
            end
        end
        if (acc) begin
            e.op  = bi.disp_op;
            e.pc  = bi.disp_pc;
            e.imm = bi.disp_imm;
            e.rob = bi.disp_rob_tag;
            e.s1v = bi.disp_src1_valid;
            e.s1t = bi.disp_src1_tag;
            e.s1d = bi.disp_src1_data;
            e.s2v = bi.disp_src2_valid;
            e.s2t = bi.disp_src2_tag;
            e.s2d = bi.disp_src2_data;
            if (!e.s1v && bi.cdb_valid && e.s1t == bi.cdb_tag) begin
                e.s1v = 1'b1;
                e.s1d = bi.cdb_data;
            end
            if (!e.s2v && bi.cdb_valid && e.s2t == bi.cdb_tag) begin
                e.s2v = 1'b1;
                e.s2d = bi.cdb_data;
            end
            mq.push_back(e);
        end
    endtask

    // ---------------- clock/reset and driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_idle();
        bi.flush           = 1'b0;
        bi.disp_valid      = 1'b0;
        bi.disp_op         = '0;
        bi.disp_pc         = '0;
        bi.disp_imm        = '0;
        bi.disp_rob_tag    = '0;
        bi.disp_src1_valid = 1'b0;
        bi.disp_src2_valid = 1'b0;
        bi.disp_src1_tag   = '0;
        bi.disp_src2_tag   = '0;
        bi.disp_src1_data  = '0;
        bi.disp_src2_data  = '0;
        bi.cdb_valid       = 1'b0;
        bi.cdb_tag         = '0;
        bi.cdb_data        = '0;
        bi.res_ready       = 1'b1;
    endtask

    task automatic disp_set(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] imm,
                            input logic [TAG_W-1:0] rob,
                            input logic s1v, input logic [TAG_W-1:0] s1t, input logic [31:0] s1d,
                            input logic s2v, input logic [TAG_W-1:0] s2t, input logic [31:0] s2d);
        bi.disp_valid      = 1'b1;
        bi.disp_op         = op;
        bi.disp_pc         = pc;
        bi.disp_imm        = imm;
        bi.disp_rob_tag    = rob;
        bi.disp_src1_valid = s1v;
        bi.disp_src1_tag   = s1t;
        bi.disp_src1_data  = s1d;
        bi.disp_src2_valid = s2v;
        bi.disp_src2_tag   = s2t;
        bi.disp_src2_data  = s2d;
    endtask

    task automatic dispatch(input logic [2:0] op, input logic [31:0] pc, input logic [31:0] imm,
                            input logic [TAG_W-1:0] rob,
                            input logic s1v, input logic [TAG_W-1:0] s1t, input logic [31:0] s1d,
                            input logic s2v, input logic [TAG_W-1:0] s2t, input logic [31:0] s2d);
        logic ok;
        ok = 1'b0;
        disp_set(op, pc, imm, rob, s1v, s1t, s1d, s2v, s2t, s2d);
        for (int k = 0; k < 20 && !ok; k++) begin
            ok = bi.disp_ready;
            tick();
        end
        bi.disp_valid = 1'b0;
        if (!ok) fail_now("dispatch_accept");
    endtask

    task automatic cdb_pulse(input logic [TAG_W-1:0] tag, input logic [31:0] data);
        bi.cdb_valid = 1'b1;
        bi.cdb_tag   = tag;
        bi.cdb_data  = data;
        tick();
        bi.cdb_valid = 1'b0;
    endtask

    // ---------------- scoreboard: every-cycle compare against the model ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("res_valid", 32'(bi.res_valid), 32'(m_rv));
                check("disp_ready", 32'(bi.disp_ready), 32'(mq.size() < DEPTH));
                if (m_rv) begin
                    check("res_rob_tag", 32'(bi.res_rob_tag), 32'(m_tag));
                    check("res_taken", 32'(bi.res_taken), 32'(m_taken));
                    check("res_target", bi.res_target, m_target);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        set_idle();
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_res_valid", 32'(bi.res_valid), 32'd0);
        check("reset_res_rob_tag", 32'(bi.res_rob_tag), 32'd0);
        check("reset_res_taken", 32'(bi.res_taken), 32'd0);
        check("reset_res_target", bi.res_target, 32'd0);
        check("reset_disp_ready", 32'(bi.disp_ready), 32'd1);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Ready beq: result one edge after the entry is written.
        dispatch(3'b000, 32'h100, 32'h20, 3'd1, 1'b1, 3'd0, 32'h5, 1'b1, 3'd0, 32'h5);
        check("beq_not_yet", 32'(bi.res_valid), 32'd0);
        tick();
        check("beq_valid", 32'(bi.res_valid), 32'd1);
        check("beq_taken", 32'(bi.res_taken), 32'd1);
        check("beq_target", bi.res_target, 32'h120);
        tick();
        check("beq_retired", 32'(bi.res_valid), 32'd0);

        // blt waiting on tag 3: -1 < 0 signed.
        dispatch(3'b100, 32'h200, 32'hFFFF_FFF0, 3'd2, 1'b0, 3'd3, 32'h0, 1'b1, 3'd0, 32'h0);
        cdb_pulse(3'd3, 32'hFFFF_FFFF);
        check("blt_capture_edge", 32'(bi.res_valid), 32'd0);
        tick();
        check("blt_valid", 32'(bi.res_valid), 32'd1);
        check("blt_taken", 32'(bi.res_taken), 32'd1);
        check("blt_target", bi.res_target, 32'h1F0);
        tick();

        // bltu with the same operands: 0xFFFFFFFF is not below 0 unsigned.
        dispatch(3'b110, 32'h300, 32'h8, 3'd3, 1'b0, 3'd3, 32'h0, 1'b1, 3'd0, 32'h0);
        cdb_pulse(3'd3, 32'hFFFF_FFFF);
        tick();
        check("bltu_valid", 32'(bi.res_valid), 32'd1);
        check("bltu_taken", 32'(bi.res_taken), 32'd0);
        check("bltu_target", bi.res_target, 32'h308);
        tick();

        // Ordering: A waits on tag 2, B is ready behind it.
        dispatch(3'b001, 32'h400, 32'h4, 3'd4, 1'b0, 3'd2, 32'h0, 1'b1, 3'd0, 32'h7);
        dispatch(3'b000, 32'h500, 32'h10, 3'd5, 1'b1, 3'd0, 32'h1, 1'b1, 3'd0, 32'h1);
        tick();
        check("order_b_held", 32'(bi.res_valid), 32'd0);
        cdb_pulse(3'd2, 32'h9);
        tick();
        check("order_first_tag", 32'(bi.res_rob_tag), 32'd4);
        check("order_first_taken", 32'(bi.res_taken), 32'd1);
        tick();
        check("order_second_tag", 32'(bi.res_rob_tag), 32'd5);
        check("order_second_target", bi.res_target, 32'h510);
        tick();
        check("order_drained", 32'(bi.res_valid), 32'd0);

        // Backpressure: four queued plus one in the result register.
        bi.res_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            dispatch(3'b000, 32'h1000 + 32'(k * 16), 32'h4, TAG_W'(k + 1),
                     1'b1, 3'd0, 32'(k), 1'b1, 3'd0, 32'(k));
            exp_q.push_back(TAG_W'(k + 1));
        end
        check("full_disp_ready", 32'(bi.disp_ready), 32'd0);
        disp_set(3'b000, 32'h2000, 32'h4, 3'd6, 1'b1, 3'd0, 32'h0, 1'b1, 3'd0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_rob_tag", 32'(bi.res_rob_tag), 32'd1);
            check("stall_target", bi.res_target, 32'h1004);
            check("stall_disp_ready", 32'(bi.disp_ready), 32'd0);
        end
        bi.disp_valid = 1'b0;
        bi.res_ready  = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
            if (bi.res_valid) check("drain_order", 32'(bi.res_rob_tag), 32'(exp_q.pop_front()));
            tick();
        end
        if (exp_q.size() != 0) fail_now("drain_complete");
        check("drain_idle", 32'(bi.res_valid), 32'd0);

        // Flush with a result pending and three entries waiting on tag 5.
        bi.res_ready = 1'b0;
        dispatch(3'b000, 32'h600, 32'h4, 3'd1, 1'b1, 3'd0, 32'h0, 1'b1, 3'd0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            dispatch(3'b001, 32'h700, 32'h4, TAG_W'(k + 2), 1'b0, 3'd5, 32'h0, 1'b1, 3'd0, 32'h3);
        end
        check("preflush_res_valid", 32'(bi.res_valid), 32'd1);
        bi.flush = 1'b1;
        tick();
        bi.flush = 1'b0;
        check("flush_res_valid", 32'(bi.res_valid), 32'd0);
        check("flush_disp_ready", 32'(bi.disp_ready), 32'd1);
        bi.res_ready = 1'b1;
        cdb_pulse(3'd5, 32'h8);
        tick();
        check("flush_stale_wakeup", 32'(bi.res_valid), 32'd0);

        // Asynchronous reset between edges.
        bi.res_ready = 1'b0;
        dispatch(3'b000, 32'h800, 32'h4, 3'd6, 1'b1, 3'd0, 32'h0, 1'b1, 3'd0, 32'h0);
        dispatch(3'b000, 32'h900, 32'h4, 3'd7, 1'b1, 3'd0, 32'h0, 1'b1, 3'd0, 32'h0);
        check("prereset_res_valid", 32'(bi.res_valid), 32'd1);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_res_valid", 32'(bi.res_valid), 32'd0);
        check("async_disp_ready", 32'(bi.disp_ready), 32'd1);
        check("async_res_target", bi.res_target, 32'd0);
        #1;
        rst = 1'b0;
        set_idle();

        // Randomized traffic, checked every cycle by the scoreboard.
        for (int n = 0; n < 3000; n++) begin
            bi.flush           = ($urandom_range(0, 39) == 0);
            bi.disp_valid      = $urandom_range(0, 1) == 1;
            bi.disp_op         = 3'($urandom_range(0, 7));
            bi.disp_pc         = $urandom;
            bi.disp_imm        = $urandom;
            bi.disp_rob_tag    = TAG_W'($urandom_range(0, 7));
            bi.disp_src1_valid = $urandom_range(0, 1) == 1;
            bi.disp_src2_valid = $urandom_range(0, 1) == 1;
            bi.disp_src1_tag   = TAG_W'($urandom_range(0, 7));
            bi.disp_src2_tag   = TAG_W'($urandom_range(0, 7));
            bi.disp_src1_data  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
            bi.disp_src2_data  = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
            bi.cdb_valid       = $urandom_range(0, 1) == 1;
            bi.cdb_tag         = TAG_W'($urandom_range(0, 7));
            bi.cdb_data        = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom;
            bi.res_ready       = $urandom_range(0, 3) != 0;
            tick();
        end

        set_idle();
        repeat (4) tick();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/branch_issue_queue.md
Name: branch_issue_queue

Overview:
- In-order issue queue and sequencer for the shared branch comparator in the OOO core.
- Accepts decoded conditional branches from dispatch and holds them until both source operands are valid, snooping the CDB for missing operands.
- Issues the oldest branch to one branch_alu instance, computes the target, and registers the result for the ROB/CDB with a valid/ready handshake.
- Whole queue is cleared on a pipeline flush.

Parameters:
- DEPTH, 4, number of queue entries (power of two, ≥2).
- TAG_W, 3, width of ROB/physical tags carried on dispatch and CDB.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  mispredict/exception flush; clears queue and output register.
- disp_valid  in  1  dispatch presents a branch.
- disp_ready  out  1  queue can accept; equals !full, registered-state only.
- disp_op  in  3  branch_funct3_t compare op.
- disp_pc  in  32  branch PC.
- disp_imm  in  32  sign-extended B-immediate.
- disp_rob_tag  in  TAG_W  destination ROB entry.
- disp_src1_valid, disp_src2_valid  in  1 each  operand already available.
- disp_src1_tag, disp_src2_tag  in  TAG_W each  producer tag when operand is not valid.
- disp_src1_data, disp_src2_data  in  32 each  operand value when valid.
- cdb_valid  in  1  CDB broadcast this cycle.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_data  in  32  broadcast value.
- res_valid  out  1  result register holds a resolved branch.
- res_ready  in  1  consumer accepts the result.
- res_rob_tag  out  TAG_W  ROB entry of the resolved branch.
- res_taken  out  1  comparator outcome.
- res_target  out  32  pc + imm, modulo 2^32.

Behaviour:
- Storage: circular FIFO with head/tail pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits. full = (count==DEPTH), empty = (count==0).
- Reset (async, rst=1): head=tail=count=0, all entry valid bits 0, res_valid=0, res_rob_tag=0, res_taken=0, res_target=0. disp_ready is therefore 1 out of reset.
- Dispatch: when disp_valid && disp_ready && !flush, write the entry at tail and increment tail (wraps) and count.
- Dispatch bypass: if a source is not valid but cdb_valid && cdb_tag matches its tag in the same cycle, store it as valid with cdb_data.
- Wakeup: each cycle, every occupied entry with an invalid source whose tag equals cdb_tag while cdb_valid captures cdb_data and sets that source valid. Both sources may wake in the same cycle.
- Issue condition: the head entry is occupied, src1 and src2 are both valid, and the output register is free (!res_valid || res_ready). Only the head may issue; no out-of-order issue.
- Issue action: drive branch_alu combinationally with head op/src1/src2. Next edge loads res_rob_tag, res_taken = answer, res_target = pc + imm; sets res_valid=1; head and count advance.
- Latency: operand valid in the entry at edge N gives res_valid at edge N+1. A CDB capture at edge N therefore gives the result at edge N+1.
- Output handshake:
  - res_valid && res_ready retires the result; res_valid drops unless a new issue occurs in the same cycle, in which case it stays high with the new payload.
  - Outputs hold stable while res_valid && !res_ready.
- Simultaneous dispatch and issue: count is unchanged. Dispatch into a full queue is blocked even if the head issues that cycle.
- Flush: synchronous and highest priority. Next edge gives head=tail=count=0, all entries invalid, res_valid=0. Dispatch and issue in the flush cycle are discarded.
- Illegal op (funct3 010/011): entry issues normally, res_taken=0, no assertion in synthesis.
- No FSM beyond the FIFO. The output register acts as a 1-entry skid stage.

Decomposition:
- rv32i_types package: reuse branch_funct3_t and rv32i_word. Add packed struct br_iq_entry_t (op, pc, imm, rob_tag, src1/src2 valid, tag and data).
- Sub-module: the existing branch_alu, instantiated once.
- Wakeup compare is a generate loop in this module; no separate sub-module.

Test Plan:
- Ready dispatch: beq, src1=src2=0x5, pc=0x100, imm=0x20 → one cycle later res_valid=1, res_taken=1, res_target=0x120.
- Wakeup: blt, src1 tag 3 pending, src2=0x0. CDB tag 3 with data 0xFFFFFFFF at edge N → res_taken=1 at edge N+1. Repeat with bltu → res_taken=0.
- Ordering: dispatch A (waiting on tag 2) then B (ready). B must not issue before A. After CDB tag 2, results appear A then B on consecutive cycles.
- Full/backpressure: hold res_ready=0 and dispatch 5 branches → disp_ready=0 after 4 accepted plus one in the output register. Outputs stay stable; releasing res_ready drains all in order.
- Flush: with 3 entries queued and res_valid=1, assert flush 1 cycle → next cycle res_valid=0, disp_ready=1. A later CDB carrying the old tags produces no result.
- Async reset: assert rst mid-operation between clock edges → res_valid=0 and disp_ready=1 immediately, without waiting for a clock edge.
